hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits directly downstream of the register file, taking the `rs`/`rt` read ports as operands for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes `hi`/`lo` to the writeback mux that serves MFHI/MFLO. The `busy` output stalls the pipeline while an operation is in flight.

---
 rtl/hilo_muldiv.sv | 159 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv
// Purpose  : Iterative 32x32 multiply / restoring divide with HI/LO registers.
// Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] c_LAST = 6'(ITER - 1);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic [31:0] r_a_orig;
    logic [31:0] r_mcand;
    logic [31:0] r_divisor;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quot;

    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_prod_next;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;
    logic [31:0] w_rem_next;
    logic [31:0] w_quot_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    always_comb begin
        // op[0] selects the unsigned variant, so only signed ops see a sign bit
        w_rs_neg = ~op[0] & rs[31];
        w_rt_neg = ~op[0] & rt[31];
        w_rs_mag = w_rs_neg ? (~rs + 32'd1) : rs;
        w_rt_mag = w_rt_neg ? (~rt + 32'd1) : rt;

        // Shift-add: the multiplier sits in the low half and drains out LSB first
        w_mul_sum   = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
        w_prod_next = {w_mul_sum, r_prod[31:1]};

        // Restoring step; the remainder is always below the divisor so bit 32 of
        // the difference is a clean borrow flag
        w_shift     = {r_rem, r_quot[31]};
        w_diff      = w_shift - {1'b0, r_divisor};
        w_fits      = ~w_diff[32];
        w_rem_next  = w_fits ? w_diff[31:0] : w_shift[31:0];
        w_quot_next = {r_quot[30:0], w_fits};

        w_prod_fix = r_neg_q ? (~w_prod_next + 64'd1) : w_prod_next;
        w_quot_fix = r_neg_q ? (~w_quot_next + 32'd1) : w_quot_next;
        w_rem_fix  = r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_orig   <= 32'd0;
            r_mcand    <= 32'd0;
            r_divisor  <= 32'd0;
            r_prod     <= 64'd0;
            r_rem      <= 32'd0;
            r_quot     <= 32'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_is_div   <= op[1];
                                r_neg_q    <= w_rs_neg ^ w_rt_neg;
                                r_neg_r    <= w_rs_neg;
                                r_div_zero <= (rt == 32'd0);
                                r_a_orig   <= rs;
                                r_mcand    <= w_rs_mag;
                                r_divisor  <= w_rt_mag;
                                r_prod     <= {32'd0, w_rt_mag};
                                r_rem      <= 32'd0;
                                r_quot     <= w_rs_mag;
                                r_cnt      <= 6'd0;
                                r_state    <= S_RUN;
                            end
                            3'b100:  hi <= rs;
                            3'b101:  lo <= rs;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                    end else begin
                        r_prod <= w_prod_next;
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 6'd0;
                        done    <= 1'b1;
                        if (r_is_div) begin
                            // Divide by zero returns the untouched dividend in HI
                            if (r_div_zero) begin
                                hi <= r_a_orig;
                                lo <= 32'hFFFF_FFFF;
                            end else begin
                                hi <= w_rem_fix;
                                lo <= w_quot_fix;
                            end
                        end else begin
                            hi <= w_prod_fix[63:32];
                            lo <= w_prod_fix[31:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv
// Purpose  : Randomized scoreboard bench for hilo_muldiv against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    hilo_muldiv #(.ITER(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} computed with plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a;
                sb = b;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding op
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                chk("result", {hi, lo}, sb_q.pop_front());
            end
        end
    end

    // Called at a negedge; leaves the bench at a negedge for mult/div or posedge+1 otherwise
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit poke_mthi);
        logic [63:0] prev;
        int          nb;
        prev  = {hi, lo};
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs    = $urandom;
        rt    = $urandom;
        if (o == 3'b100) begin
            chk("mthi", {hi, lo}, {a, prev[31:0]});
            chk("mt_flags", {62'd0, busy, done}, 64'd0);
        end else if (o == 3'b101) begin
            chk("mtlo", {hi, lo}, {prev[63:32], a});
            chk("mt_flags", {62'd0, busy, done}, 64'd0);
        end else if (o[2]) begin
            chk("reserved_hold", {hi, lo}, prev);
            chk("reserved_flags", {62'd0, busy, done}, 64'd0);
        end else begin
            sb_q.push_back(ref_model(o, a, b));
            nb = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (poke_mthi && i == 3) begin
                    start = 1'b1;
                    op    = 3'b100;
                    rs    = 32'hAAAA_5555;
                end else if (i == 4) begin
                    start = 1'b0;
                end
                if (i < 31) chk("hold_while_busy", {hi, lo}, prev);
                if (busy) nb++;
                else break;
            end
            chk("busy_cycles", 64'(nb), 64'd32);
            chk("done_pulse", {63'd0, done}, 64'd1);
        end
    endtask

    initial begin
        int nd;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        rs    = 32'd0;
        rt    = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", {hi, lo}, 64'd0);
        chk("reset_flags", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'b101, 32'h1234_5678, 32'd0, 1'b0);
        issue(3'b100, 32'hCAFE_0001, 32'd0, 1'b0);
        // Asynchronous reset with no clock edge in between
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {hi, lo}, 64'd0);
        chk("async_reset_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0);
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(3'b011, 32'd7, 32'd0, 1'b0);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(3'b010, 32'd1000, 32'hFFFF_FFFD, 1'b1);

        // Reset in the middle of a divide discards it
        start = 1'b1;
        op    = 3'b010;
        rs    = 32'd12345;
        rt    = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset_mid_div", {hi, lo}, 64'd0);
        chk("reset_mid_div_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_reset", 64'(nd), 64'd0);
        issue(3'b001, 32'd2, 32'd3, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            issue(o, rnd_operand(), rnd_operand(), ($urandom_range(0, 3) == 0));
            if (o[2]) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
